acc_ctrl: RTL

Command sequencer that drives the control inputs of the split high/low accumulator (`acc`). It accepts one micro-operation per valid/ready handshake and expands it into the per-cycle select, fill, read-enable and high-clear strobes the accumulator expects. Multi-cycle shifts and bus-out windows are handled here, so the instruction decoder issues one command per operation.

---
 rtl/acc_pkg.sv | 23 ++
 rtl/acc_ctrl_fifo.sv | 41 ++++
 rtl/acc_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared encodings for the accumulator control path (selects, sources, opcodes, sequencer states).
package acc_pkg;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  localparam logic SRC_BUS = 1'b0;
  localparam logic SRC_ALU = 1'b1;
  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_LDH_BUS = 4'd1,
    OP_LDH_ALU = 4'd2,
    OP_LDL_BUS = 4'd3,
    OP_LDL_ALU = 4'd4,
    OP_LD8_BUS = 4'd5,
    OP_SHL     = 4'd6,
    OP_SHR     = 4'd7,
    OP_CLRH    = 4'd8,
    OP_OUT     = 4'd9
  } acc_op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [3:0] OP_LAST = 4'd9;
endpackage

// File: rtl/acc_ctrl_fifo.sv
// acc_ctrl_fifo: 2-entry command FIFO placed in front of the acc_ctrl sequencer.
module acc_ctrl_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] n_q, n_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = wdata;
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ pop;
    n_d = n_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      n_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      n_q <= n_d;
    end
  end
  assign rdata = mem_q[rp_q];
  assign full = n_q == 2'd2;
  assign empty = n_q == 2'd0;
endmodule

// File: rtl/acc_ctrl.sv
// acc_ctrl: expands one handshaked micro-op into per-cycle accumulator strobes.
// Define ACC_CTRL_CMD_QUEUE_EN to put a 2-entry command FIFO in front of the FSM.
module acc_ctrl import acc_pkg::*; #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  output logic [1:0]       acc_high_select,
  output logic [1:0]       acc_low_select,
  output logic             acc_in_select,
  output logic             fill_value,
  output logic             rd_en,
  output logic             acc_high_reset_p,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t state_q, state_d;
  acc_op_t op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, src_cnt;
  logic fill_q, fill_d, err_q, err_d, src_fill, take, legal, multi, stay;
  logic [3:0] src_op;
`ifdef ACC_CTRL_CMD_QUEUE_EN
  logic full, empty, push, pop;
  logic [3:0] f_op;
  logic [CNT_W-1:0] f_cnt;
  logic f_fill;
  // An empty queue lets the incoming command go straight to the FSM with no extra latency.
  assign cmd_ready = !full;
  assign take = state_q != S_RUN && (!empty || cmd_valid);
  assign pop = take && !empty;
  assign push = cmd_valid && !full && !(take && empty);
  assign {src_op, src_cnt, src_fill} = empty ? {cmd_op, cmd_count, cmd_fill} : {f_op, f_cnt, f_fill};
  acc_ctrl_fifo #(.W(5 + CNT_W)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .wdata({cmd_op, cmd_count, cmd_fill}),
    .pop(pop),
    .rdata({f_op, f_cnt, f_fill}),
    .full(full),
    .empty(empty)
  );
`else
  assign cmd_ready = state_q == S_IDLE;
  assign take = cmd_ready && cmd_valid;
  assign {src_op, src_cnt, src_fill} = {cmd_op, cmd_count, cmd_fill};
`endif
  assign legal = src_op <= OP_LAST;
  assign multi = op_q inside {OP_SHL, OP_SHR, OP_OUT};
  // Count 0 runs 2^CNT_W cycles: the counter wraps from 0 to all-ones and leaves RUN at 1.
  assign stay = multi && cnt_q != CNT_W'(1);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    fill_d = fill_q;
    err_d = err_q;
    if (take) begin
      state_d = S_RUN;
      op_d = legal ? acc_op_t'(src_op) : OP_NOP;
      cnt_d = src_cnt;
      fill_d = src_fill;
      err_d = err_q | !legal;
    end else if (state_q == S_RUN) begin
      state_d = stay ? S_RUN : S_DONE;
      cnt_d = stay ? cnt_q - CNT_W'(1) : cnt_q;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q <= OP_NOP;
      cnt_q <= '0;
      fill_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    acc_high_select = SEL_HOLD;
    acc_low_select = SEL_HOLD;
    acc_in_select = SRC_BUS;
    fill_value = 1'b0;
    rd_en = 1'b0;
    acc_high_reset_p = 1'b0;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_LDH_BUS: acc_high_select = SEL_LOAD;
        OP_LDH_ALU: {acc_high_select, acc_in_select} = {SEL_LOAD, SRC_ALU};
        OP_LDL_BUS: acc_low_select = SEL_LOAD;
        OP_LDL_ALU: {acc_low_select, acc_in_select} = {SEL_LOAD, SRC_ALU};
        OP_LD8_BUS: {acc_high_select, acc_low_select} = {SEL_LOAD, SEL_LOAD};
        OP_SHL: {acc_high_select, acc_low_select, fill_value} = {SEL_SHL, SEL_SHL, fill_q};
        OP_SHR: {acc_high_select, acc_low_select, fill_value} = {SEL_SHR, SEL_SHR, fill_q};
        OP_CLRH: acc_high_reset_p = 1'b1;
        OP_OUT: rd_en = 1'b1;
        default: ;
      endcase
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign err = err_q;
endmodule
